alu_issue_controller: RTL and testbench

ALU_ISSUE_CONTROLLER -- requirements
Module: alu_issue_controller

---
 rtl/alu_issue_controller_pkg.sv | 45 ++++
 rtl/alu_issue_controller_regfile.sv | 45 ++++
 rtl/alu_issue_controller.sv | 142 ++++++++++++++
 tb/tb_alu_issue_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_controller_pkg.sv
// ============================================================================
// Module  : alu_issue_controller_pkg
// Brief   : Shared opcodes, function-select codes, FSM states and widths for
//           the issue controller and its external functional unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_controller_pkg;

  localparam int DATA_W = 16;
  localparam int RIDX_W = 3;
  localparam int OP_W   = 4;
  localparam int FS_W   = 3;
  localparam int IMM_W  = 9;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLA = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0111;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1000;

  localparam logic [FS_W-1:0] FS_ADD = 3'b000;
  localparam logic [FS_W-1:0] FS_SUB = 3'b001;
  localparam logic [FS_W-1:0] FS_AND = 3'b010;
  localparam logic [FS_W-1:0] FS_OR  = 3'b011;
  localparam logic [FS_W-1:0] FS_XOR = 3'b100;
  localparam logic [FS_W-1:0] FS_NOT = 3'b101;
  localparam logic [FS_W-1:0] FS_SLA = 3'b110;
  localparam logic [FS_W-1:0] FS_SRA = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_controller_regfile.sv
// ============================================================================
// Module  : alu_regfile
// Brief   : Register file, two operand read ports, one write port, plus a
//           debug read port. R0 is hardwired to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [AW-1:0]     i_raddr_dbg,
  output logic [DATA_W-1:0] o_rdata_dbg
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = (i_raddr_a   == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b   == '0) ? '0 : r_mem[i_raddr_b];
  assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 : r_mem[i_raddr_dbg];

endmodule

`default_nettype wire

// File: rtl/alu_issue_controller.sv
// ============================================================================
// Module  : alu_issue_controller
// Brief   : Four-state issue FSM feeding an external functional unit and
//           writing results back into an 8-entry register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_controller #(
  parameter int DATA_W = alu_issue_controller_pkg::DATA_W,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        FS,
  output logic [DATA_W-1:0] inS,
  output logic [DATA_W-1:0] inT,
  input  logic [DATA_W-1:0] F,
  output logic              done,
  output logic              err,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_issue_controller_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_instr;
  logic [FS_W-1:0]       r_fs;
  logic [DATA_W-1:0]     r_ins;
  logic [DATA_W-1:0]     r_int;
  logic [DATA_W-1:0]     r_result;
  logic                  r_done;
  logic                  r_err;

  logic [OP_W-1:0]       w_op;
  logic [RIDX_W-1:0]     w_rd;
  logic [RIDX_W-1:0]     w_rs;
  logic [RIDX_W-1:0]     w_rt;
  logic [IMM_W-1:0]      w_imm9;
  logic                  w_is_alu;
  logic                  w_is_ldi;
  logic                  w_illegal;
  logic                  w_we;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_rdata_s;
  logic [DATA_W-1:0]     w_rdata_t;

  assign w_op      = r_instr[15:12];
  assign w_rd      = r_instr[11:9];
  assign w_rs      = r_instr[8:6];
  assign w_rt      = r_instr[5:3];
  assign w_imm9    = r_instr[8:0];
  assign w_is_alu  = ~w_op[3];
  assign w_is_ldi  = (w_op == OP_LDI);
  assign w_illegal = w_op[3] & ~w_is_ldi;

  assign instr_ready = (r_state == ST_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (instr_valid) w_next = ST_DECODE;
      ST_DECODE:    w_next = ST_EXECUTE;
      ST_EXECUTE:   w_next = ST_WRITEBACK;
      ST_WRITEBACK: w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // done/err are registered at the end of EXECUTE so they are high exactly
  // for the WRITEBACK cycle, together with the register write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr  <= '0;
      r_fs     <= '0;
      r_ins    <= '0;
      r_int    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_IDLE && instr_valid) begin
        r_instr <= instr;
      end
      if (r_state == ST_DECODE && w_is_alu) begin
        r_fs  <= w_op[FS_W-1:0];
        r_ins <= w_rdata_s;
        r_int <= w_rdata_t;
      end
      if (r_state == ST_EXECUTE) begin
        r_result <= F;
        r_done   <= 1'b1;
        r_err    <= w_illegal;
      end
    end
  end

  assign w_we    = (r_state == ST_WRITEBACK) && (w_is_alu || w_is_ldi);
  assign w_wdata = w_is_ldi ? {{(DATA_W-IMM_W){w_imm9[IMM_W-1]}}, w_imm9} : r_result;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (RIDX_W)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_waddr     (w_rd),
    .i_wdata     (w_wdata),
    .i_raddr_a   (w_rs),
    .o_rdata_a   (w_rdata_s),
    .i_raddr_b   (w_rt),
    .o_rdata_b   (w_rdata_t),
    .i_raddr_dbg (dbg_addr),
    .o_rdata_dbg (dbg_data)
  );

  assign FS   = r_fs;
  assign inS  = r_ins;
  assign inT  = r_int;
  assign done = r_done;
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_controller.sv
// ============================================================================
// Module  : tb_alu_issue_controller
// Brief   : Self-checking bench with a behavioural functional unit, a vector
//           table and a scoreboard of expected retirements.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/10ps

module tb_alu_issue_controller;

  import alu_issue_controller_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic [2:0]    FS;
  logic [DW-1:0] inS;
  logic [DW-1:0] inT;
  logic [DW-1:0] F;
  logic          done;
  logic          err;
  logic [2:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_controller #(.DATA_W(DW), .NREG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .FS          (FS),
    .inS         (inS),
    .inT         (inT),
    .F           (F),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural functional unit; shifts are by one bit.
  always_comb begin
    F = '0;
    case (FS)
      FS_ADD: F = inS + inT;
      FS_SUB: F = inS - inT;
      FS_AND: F = inS & inT;
      FS_OR:  F = inS | inT;
      FS_XOR: F = inS ^ inT;
      FS_NOT: F = ~inS;
      FS_SLA: F = inS << 1;
      FS_SRA: F = $signed(inS) >>> 1;
      default: F = '0;
    endcase
  end

  typedef struct {
    logic [15:0]   ins;
    logic          exp_err;
    logic [DW-1:0] exp_val;
  } vec_t;

  typedef struct {
    logic [2:0]    rd;
    logic          err;
    logic [DW-1:0] val;
    logic          alu;
    logic [2:0]    fs;
    logic [DW-1:0] s;
    logic [DW-1:0] t;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] ref_r [8];
  vec_t          vecs [16];
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input int rd, input int rs, input int rt);
    logic [2:0] d, s, t;
    d = rd[2:0]; s = rs[2:0]; t = rt[2:0];
    return {op, d, s, t, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input logic [8:0] imm);
    logic [2:0] d;
    d = rd[2:0];
    return {OP_LDI, d, imm};
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #0.1;
      check($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, ref_r[i]});
    end
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic exp_err, input logic [DW-1:0] exp_val);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", {31'h0, instr_ready}, 32'h1);
    e.rd  = ins[11:9];
    e.err = exp_err;
    e.val = exp_val;
    e.alu = ~ins[15];
    e.fs  = ins[14:12];
    e.s   = ref_r[ins[8:6]];
    e.t   = ref_r[ins[5:3]];
    sbq.push_back(e);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 1;
    while (!done && lat <= 8) begin
      if (lat == 2 && e.alu) begin
        check("exec_FS",  {29'h0, FS}, {29'h0, e.fs});
        check("exec_inS", {16'h0, inS}, {16'h0, e.s});
        check("exec_inT", {16'h0, inT}, {16'h0, e.t});
      end
      @(posedge clk); #1;
      lat++;
    end
    got = sbq.pop_front();
    if (!done) begin
      check("done_timeout", 32'h0, 32'h1);
      return;
    end
    check("latency", lat, 32'd3);
    check("err_flag", {31'h0, err}, {31'h0, got.err});
    @(posedge clk); #1;
    check("done_pulse_end", {31'h0, done}, 32'h0);
    if (!got.err) ref_r[got.rd] = got.val;
    check_regs("regs");
  endtask

  initial begin
    int ready_cnt;
    int done_cnt;

    vecs[0]  = '{ldi(1, 9'd5),                 1'b0, 16'h0005};
    vecs[1]  = '{ldi(2, 9'h1FD),               1'b0, 16'hFFFD};
    vecs[2]  = '{enc(OP_ADD, 3, 1, 2),         1'b0, 16'h0002};
    vecs[3]  = '{enc(OP_SRA, 4, 2, 0),         1'b0, 16'hFFFE};
    vecs[4]  = '{enc(OP_SLA, 5, 1, 0),         1'b0, 16'h000A};
    vecs[5]  = '{enc(OP_SUB, 6, 1, 2),         1'b0, 16'h0008};
    vecs[6]  = '{enc(OP_AND, 7, 3, 4),         1'b0, 16'h0002};
    vecs[7]  = '{enc(OP_OR,  3, 5, 1),         1'b0, 16'h000F};
    vecs[8]  = '{enc(OP_XOR, 4, 2, 5),         1'b0, 16'hFFF7};
    vecs[9]  = '{enc(OP_NOT, 5, 3, 0),         1'b0, 16'hFFF0};
    vecs[10] = '{ldi(0, 9'd7),                 1'b0, 16'h0000};
    vecs[11] = '{enc(4'b1111, 6, 1, 2),        1'b1, 16'h0000};
    vecs[12] = '{enc(4'b1001, 2, 1, 1),        1'b1, 16'h0000};
    vecs[13] = '{ldi(6, 9'h100),               1'b0, 16'hFF00};
    vecs[14] = '{ldi(7, 9'h0FF),               1'b0, 16'h00FF};
    vecs[15] = '{enc(OP_ADD, 1, 6, 7),         1'b0, 16'hFFFF};

    for (int i = 0; i < 8; i++) ref_r[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_done",  {31'h0, done}, 32'h0);
    check("rst_err",   {31'h0, err}, 32'h0);
    check("rst_FS",    {29'h0, FS}, 32'h0);
    check("rst_inS",   {16'h0, inS}, 32'h0);
    check("rst_inT",   {16'h0, inT}, 32'h0);
    rst = 1'b0;
    check("post_rst_ready", {31'h0, instr_ready}, 32'h1);
    check_regs("rst");

    for (int i = 0; i < 16; i++) begin
      run_instr(vecs[i].ins, vecs[i].exp_err, vecs[i].exp_val);
    end

    // Continuous valid: one accept per IDLE visit, one in four cycles.
    ready_cnt = 0;
    done_cnt  = 0;
    instr = ldi(7, 9'd1);
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (instr_ready) ready_cnt++;
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check("stream_ready_cnt", ready_cnt, 32'd4);
    check("stream_done_cnt",  done_cnt,  32'd4);
    ref_r[7] = 16'h0001;
    check_regs("stream");

    // Reset while ADD r6,r1,r1 is in EXECUTE.
    ref_r[1] = 16'hFFFF;
    instr = enc(OP_ADD, 6, 1, 1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_exec_FS", {29'h0, FS}, {29'h0, FS_ADD});
    rst = 1'b1;
    #1;
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_FS",   {29'h0, FS}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'h0, instr_ready}, 32'h1);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_ready_idle", {31'h0, instr_ready}, 32'h1);
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    check_regs("abort");

    sbq.delete();
    run_instr(ldi(3, 9'h1FF), 1'b0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
